scr1_dpmem_dma: RTL and testbench

SCR1_DPMEM_DMA -- requirements
Module: scr1_dpmem_dma

---
 rtl/scr1_dpmem_dma_pkg.sv | 22 ++
 rtl/scr1_dpmem_dma.sv | 155 +++++++++++++++
 tb/tb_scr1_dpmem_dma.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_dpmem_dma_pkg.sv
// Shared types for the dual-port memory DMA engine: FSM states, status codes
// and command mode encodings.
package scr1_dpmem_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } dma_state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_RANGE   = 2'b01,
        STAT_OVERLAP = 2'b10,
        STAT_ABORTED = 2'b11
    } dma_status_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/scr1_dpmem_dma.sv
// Word-granular COPY/FILL engine for a dual-port RAM: port A reads, port B writes.
// Reads have one cycle of latency, so COPY writes trail reads by one cycle.
module scr1_dpmem_dma
    import scr1_dpmem_dma_pkg::*;
#(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_SIZE   = 32'h00010000,
    parameter int SCR1_NBYTES = SCR1_WIDTH / 8,
    localparam int AW    = $clog2(SCR1_SIZE) - 2,
    localparam int WORDS = SCR1_SIZE / SCR1_NBYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [AW-1:0]          src_addr,
    input  logic [AW-1:0]          dst_addr,
    input  logic [AW:0]            len,
    input  logic [SCR1_WIDTH-1:0]  fill_data,
    input  logic [SCR1_NBYTES-1:0] fill_be,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             status,
    output logic                   mem_rena,
    output logic [AW-1:0]          mem_addra,
    input  logic [SCR1_WIDTH-1:0]  mem_qa,
    output logic                   mem_renb,
    output logic                   mem_wenb,
    output logic [SCR1_NBYTES-1:0] mem_webb,
    output logic [AW-1:0]          mem_addrb,
    output logic [SCR1_WIDTH-1:0]  mem_datab
);

    localparam logic [AW+1:0] WORDS_W = (AW+2)'(WORDS);

    dma_state_e              r_state;
    dma_state_e              w_state_nxt;
    dma_status_e             r_status;
    logic                    r_mode;
    logic [AW-1:0]           r_rd_addr;
    logic [AW-1:0]           r_wr_addr;
    logic [AW:0]             r_remain;
    logic [SCR1_WIDTH-1:0]   r_fill_data;
    logic [SCR1_NBYTES-1:0]  r_fill_be;
    logic                    r_rd_vld;

    logic [AW+1:0]           w_src_end;
    logic [AW+1:0]           w_dst_end;
    logic                    w_range;
    logic                    w_overlap;
    logic                    w_accept;
    logic                    w_rena;
    logic                    w_wenb;

    // Command checks are evaluated on the raw inputs during the start cycle.
    assign w_src_end = {2'b00, src_addr} + {1'b0, len};
    assign w_dst_end = {2'b00, dst_addr} + {1'b0, len};
    assign w_range   = ((mode == MODE_COPY) && (w_src_end > WORDS_W)) || (w_dst_end > WORDS_W);
    assign w_overlap = (mode == MODE_COPY) && (src_addr < dst_addr) && ({2'b00, dst_addr} < w_src_end);
    assign w_accept  = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_rena      = 1'b0;
        w_wenb      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_range || w_overlap || (len == '0)) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_rena = (r_mode == MODE_COPY);
                w_wenb = (r_mode == MODE_FILL) || r_rd_vld;
                if (abort) begin
                    w_state_nxt = ST_FIN;
                end else if (r_remain == (AW+1)'(1)) begin
                    w_state_nxt = (r_mode == MODE_COPY) ? ST_DRAIN : ST_FIN;
                end
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                w_wenb      = r_rd_vld;
                w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status    <= STAT_OK;
            r_mode      <= MODE_COPY;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_remain    <= '0;
            r_fill_data <= '0;
            r_fill_be   <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            // A read aborted in flight must not turn into a write.
            r_rd_vld <= w_rena && !abort;
            if (w_accept) begin
                r_mode      <= mode;
                r_rd_addr   <= src_addr;
                r_wr_addr   <= dst_addr;
                r_remain    <= len;
                r_fill_data <= fill_data;
                r_fill_be   <= fill_be;
                r_status    <= w_range ? STAT_RANGE : (w_overlap ? STAT_OVERLAP : STAT_OK);
            end
            if (w_rena) begin
                r_rd_addr <= r_rd_addr + AW'(1);
            end
            if (w_wenb) begin
                r_wr_addr <= r_wr_addr + AW'(1);
            end
            if (r_state == ST_RUN) begin
                r_remain <= r_remain - (AW+1)'(1);
            end
            if (busy && abort) begin
                r_status <= STAT_ABORTED;
            end
        end
    end

    // Addresses and data are gated by their strobes so an idle bus reads all zero.
    assign mem_rena  = w_rena;
    assign mem_addra = w_rena ? r_rd_addr : '0;
    assign mem_renb  = 1'b0;
    assign mem_wenb  = w_wenb;
    assign mem_webb  = w_wenb ? ((r_mode == MODE_FILL) ? r_fill_be : '1) : '0;
    assign mem_addrb = w_wenb ? r_wr_addr : '0;
    assign mem_datab = w_wenb ? ((r_mode == MODE_FILL) ? r_fill_data : mem_qa) : '0;
    assign status    = r_status;

endmodule

// File: tb/tb_scr1_dpmem_dma.sv
// Self-checking bench for scr1_dpmem_dma: a transaction-level model predicts
// every output per cycle, plus directed cases with hand-computed results.
module tb_scr1_dpmem_dma;
    import scr1_dpmem_dma_pkg::*;

    localparam int W     = 32;
    localparam int NB    = 4;
    localparam int AW    = 14;
    localparam int WORDS = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, mode, abort;
    logic [AW-1:0] src_addr, dst_addr;
    logic [AW:0]   len;
    logic [W-1:0]  fill_data;
    logic [NB-1:0] fill_be;
    logic          busy, done;
    logic [1:0]    status;
    logic          mem_rena, mem_renb, mem_wenb;
    logic [AW-1:0] mem_addra, mem_addrb;
    logic [W-1:0]  mem_qa, mem_datab;
    logic [NB-1:0] mem_webb;

    always #5 clk = ~clk;

    scr1_dpmem_dma dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .fill_be(fill_be), .abort(abort),
        .busy(busy), .done(done), .status(status),
        .mem_rena(mem_rena), .mem_addra(mem_addra), .mem_qa(mem_qa),
        .mem_renb(mem_renb), .mem_wenb(mem_wenb), .mem_webb(mem_webb),
        .mem_addrb(mem_addrb), .mem_datab(mem_datab)
    );

    typedef struct {
        logic          busy, done, rena, wenb;
        logic [AW-1:0] addra, addrb;
        logic [NB-1:0] webb;
        logic [W-1:0]  datab;
        logic [1:0]    status;
    } rec_t;

    rec_t         exp_q[$];
    rec_t         recs[$];
    logic [1:0]   model_status = 2'b00;
    logic [W-1:0] ref_mem[WORDS];
    logic [W-1:0] bmem[WORDS];
    logic [W-1:0] qa_r = '0;
    logic         pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [W-1:0] pl_data = '0;
    int n_checks = 0, n_errors = 0;
    int cyc = 0, t0 = 0;
    int n_rd, n_wr, first_wr, last_wr, done_at;

    assign mem_qa = qa_r;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] init_val(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench-side dual-port RAM: read data appears one clock after mem_rena.
    initial begin
        for (int i = 0; i < WORDS; i++) bmem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_wenb) begin
                logic [W-1:0] wv;
                wv = bmem[mem_addrb];
                for (int b = 0; b < NB; b++)
                    if (mem_webb[b]) wv[8*b +: 8] = mem_datab[8*b +: 8];
                bmem[mem_addrb] <= wv;
            end
            if (pl_en) bmem[pl_addr] <= pl_data;
            if (mem_rena) qa_r <= bmem[mem_addra];
        end
    end

    function automatic rec_t idle_rec(input logic [1:0] st);
        rec_t r;
        r.busy = 1'b0; r.done = 1'b0; r.rena = 1'b0; r.wenb = 1'b0;
        r.addra = '0; r.addrb = '0; r.webb = '0; r.datab = '0; r.status = st;
        return r;
    endfunction

    // Per-cycle comparison against the model plus activity statistics.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec(model_status);
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("status", status, e.status);
            check("mem_rena", mem_rena, e.rena);
            check("mem_addra", mem_addra, e.addra);
            check("mem_renb", mem_renb, 1'b0);
            check("mem_wenb", mem_wenb, e.wenb);
            check("mem_webb", mem_webb, e.webb);
            check("mem_addrb", mem_addrb, e.addrb);
            check("mem_datab", mem_datab, e.datab);
            if (mem_rena) n_rd++;
            if (mem_wenb) begin
                n_wr++;
                if (first_wr < 0) first_wr = cyc - t0;
                last_wr = cyc - t0;
            end
            if (done) done_at = cyc - t0;
        end
    end

    // Command model: builds the expected trace for cycles 0..done from the
    // transfer rules (reads at 1+k, writes at 2+k for COPY, 1+k for FILL).
    task automatic model_cmd(input logic md, input int src, input int dst, input int ln,
                             input logic [W-1:0] fd, input logic [NB-1:0] fbe,
                             input int a, output int d_cyc);
        rec_t r;
        logic [1:0] st;
        int last, endc;
        bit ab;
        recs.delete();
        recs.push_back(idle_rec(model_status));
        if ((md == MODE_COPY && src + ln > WORDS) || dst + ln > WORDS) st = STAT_RANGE;
        else if (md == MODE_COPY && src < dst && dst < src + ln) st = STAT_OVERLAP;
        else st = STAT_OK;
        if (st != STAT_OK || ln == 0) begin
            r = idle_rec(st);
            r.done = 1'b1;
            recs.push_back(r);
            d_cyc = 1;
        end else begin
            last = (md == MODE_COPY) ? ln + 1 : ln;
            ab   = (a >= 1 && a <= last);
            endc = ab ? a : last;
            for (int c = 1; c <= endc; c++) begin
                r = idle_rec(STAT_OK);
                r.busy = 1'b1;
                if (md == MODE_COPY) begin
                    if (c <= ln) begin
                        r.rena = 1'b1; r.addra = AW'(src + c - 1);
                    end
                    if (c >= 2) begin
                        r.wenb = 1'b1; r.addrb = AW'(dst + c - 2);
                        r.webb = '1;   r.datab = ref_mem[src + c - 2];
                    end
                end else begin
                    r.wenb = 1'b1; r.addrb = AW'(dst + c - 1);
                    r.webb = fbe;  r.datab = fd;
                end
                recs.push_back(r);
            end
            st = ab ? STAT_ABORTED : STAT_OK;
            r = idle_rec(st);
            r.done = 1'b1;
            recs.push_back(r);
            d_cyc = endc + 1;
        end
        model_status = st;
    endtask

    task automatic apply_writes(input int upto);
        for (int c = 0; c <= upto && c < recs.size(); c++)
            if (recs[c].wenb)
                for (int b = 0; b < NB; b++)
                    if (recs[c].webb[b]) ref_mem[recs[c].addrb][8*b +: 8] = recs[c].datab[8*b +: 8];
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; first_wr = -1; last_wr = -1; done_at = -1; t0 = cyc;
    endtask

    // Called at posedge+1; that cycle is cycle 0. Returns at done+1 (idle).
    task automatic run_cmd(input logic md, input int src, input int dst, input int ln,
                           input logic [W-1:0] fd, input logic [NB-1:0] fbe,
                           input int a, input bit junk);
        int d;
        model_cmd(md, src, dst, ln, fd, fbe, a, d);
        foreach (recs[i]) exp_q.push_back(recs[i]);
        start = 1'b1; mode = md; src_addr = AW'(src); dst_addr = AW'(dst);
        len = (AW+1)'(ln); fill_data = fd; fill_be = fbe; abort = (a == 0);
        clear_stats();
        for (int c = 1; c <= d + 1; c++) begin
            @(posedge clk); #1;
            abort = (c == a);
            if (junk && c <= d) begin
                start = 1'($urandom); mode = 1'($urandom);
                src_addr = AW'($urandom); dst_addr = AW'($urandom);
                len = (AW+1)'($urandom); fill_data = $urandom; fill_be = NB'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0; abort = 1'b0;
        apply_writes(d);
    endtask

    task automatic preload(input int a, input logic [W-1:0] v);
        pl_en = 1'b1; pl_addr = AW'(a); pl_data = v; ref_mem[a] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    initial begin
        int bad, d;
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_data = '0; fill_be = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_status", status, 2'b00);
        check("rst_wenb", mem_wenb, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // COPY 0x10 -> 0x100, 4 words of a known pattern
        for (int i = 0; i < 4; i++) preload(16 + i, 32'hC0DE_0000 + i);
        run_cmd(MODE_COPY, 16, 256, 4, '0, '0, -1, 0);
        check("copy_reads", n_rd, 4);
        check("copy_first_wr", first_wr, 2);
        check("copy_last_wr", last_wr, 5);
        check("copy_done_cycle", done_at, 6);
        check("copy_status", status, 2'b00);
        for (int i = 0; i < 4; i++) check("copy_data", bmem[256 + i], 32'hC0DE_0000 + i);

        // FILL low halfwords only
        for (int i = 0; i < 4; i++) preload(32 + i, 32'hDEAD_BEEF);
        run_cmd(MODE_FILL, 0, 32, 3, 32'hA5A5_A5A5, 4'b0011, -1, 0);
        check("fill_done_cycle", done_at, 4);
        check("fill_writes", n_wr, 3);
        check("fill_reads", n_rd, 0);
        for (int i = 0; i < 3; i++) check("fill_data", bmem[32 + i], 32'hDEAD_A5A5);
        check("fill_untouched", bmem[35], 32'hDEAD_BEEF);

        // Rejections
        run_cmd(MODE_COPY, 0, WORDS - 2, 3, '0, '0, -1, 0);
        check("range_done_cycle", done_at, 1);
        check("range_status", status, 2'b01);
        check("range_strobes", n_rd + n_wr, 0);
        run_cmd(MODE_COPY, 5, 7, 4, '0, '0, -1, 0);
        check("overlap_done_cycle", done_at, 1);
        check("overlap_status", status, 2'b10);

        // len=0, then a FILL with start toggling while busy
        run_cmd(MODE_COPY, 3, 9, 0, '0, '0, -1, 0);
        check("len0_done_cycle", done_at, 1);
        check("len0_status", status, 2'b00);
        check("len0_strobes", n_rd + n_wr, 0);
        run_cmd(MODE_FILL, 0, 64, 5, 32'h1234_5678, 4'hF, -1, 1);
        check("busy_start_done_cycle", done_at, 6);
        check("busy_start_writes", n_wr, 5);
        check("busy_start_data", bmem[68], 32'h1234_5678);

        // Abort on cycle 4 of an 8-word COPY
        run_cmd(MODE_COPY, 80, 768, 8, '0, '0, 4, 0);
        check("abort_writes", n_wr, 3);
        check("abort_last_wr", last_wr, 4);
        check("abort_done_cycle", done_at, 5);
        check("abort_status", status, 2'b11);
        check("abort_untouched", bmem[771], init_val(771));

        // Reset during cycle 3 of an 8-word COPY
        model_cmd(MODE_COPY, 48, 512, 8, '0, '0, -1, d);
        foreach (recs[i]) exp_q.push_back(recs[i]);
        start = 1'b1; mode = MODE_COPY; src_addr = AW'(48); dst_addr = AW'(512); len = 15'd8;
        clear_stats();
        repeat (2) begin @(posedge clk); #1; start = 1'b0; end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_rena", mem_rena, 1'b0);
        check("arst_addra", mem_addra, '0);
        check("arst_wenb", mem_wenb, 1'b0);
        check("arst_datab", mem_datab, '0);
        check("arst_status", status, 2'b00);
        exp_q.delete();
        model_status = STAT_OK;
        apply_writes(2);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("arst_no_done", done_at, -1);
        check("arst_one_write", n_wr, 1);
        run_cmd(MODE_FILL, 0, 600, 2, 32'h0BAD_F00D, 4'hF, -1, 0);
        check("post_rst_done_cycle", done_at, 3);
        check("post_rst_data", bmem[601], 32'h0BAD_F00D);

        // Randomized commands against the model
        for (int n = 0; n < 120; n++) begin
            int s, dd, l, a;
            logic md;
            md = 1'($urandom);
            s  = $urandom_range(0, 63);
            dd = $urandom_range(0, 63);
            l  = $urandom_range(0, 24);
            case ($urandom_range(0, 7))
                0: dd = WORDS - 1 - $urandom_range(0, 15);
                1: s  = WORDS - 1 - $urandom_range(0, 15);
                default: ;
            endcase
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, l + 2) : -1;
            run_cmd(md, s, dd, l, $urandom, NB'($urandom), a, 1'($urandom));
        end

        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (bmem[i] !== ref_mem[i]) bad++;
        check("mem_final", bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
